aud_ctrl: RTL and testbench

- Top-level sequencer for the audio record/playback datapath.
- Turns debounced key pulses and mode switches into one-cycle start/pause/stop commands for the recorder and for the DSP/player block.
- Tracks the recorded end address and owns SRAM direction (recorder write vs DSP read).
- Sits between key/switch conditioning and the recorder, DSP and SRAM mux in the top module.

---
 rtl/aud_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_aud_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/aud_ctrl.sv
// Record/playback sequencer: turns key pulses into registered recorder/DSP command pulses.
// Optional AUD_CTRL_LOOP_EN: end of play restarts playback in place instead of returning to idle.
module aud_ctrl #(
   parameter int                ADDR_W   = 20,
   parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_init_done,
   input  logic              i_key_record,
   input  logic              i_key_play,
   input  logic              i_key_pause,
   input  logic              i_key_stop,
   input  logic [1:0]        i_sw_mode,
   input  logic [2:0]        i_sw_speed,
   input  logic [ADDR_W-1:0] i_rec_addr,
   input  logic [ADDR_W-1:0] i_dsp_addr,
   output logic              o_rec_start,
   output logic              o_rec_pause,
   output logic              o_rec_stop,
   output logic              o_dsp_start,
   output logic              o_dsp_pause,
   output logic              o_dsp_stop,
   output logic [2:0]        o_dsp_speed,
   output logic              o_dsp_fast,
   output logic              o_dsp_slow_0,
   output logic              o_dsp_slow_1,
   output logic              o_sram_we_n,
   output logic [ADDR_W-1:0] o_end_addr,
   output logic              o_has_data,
   output logic [2:0]        o_state
);

   typedef enum logic [2:0] {
      S_INIT       = 3'd0,
      S_IDLE       = 3'd1,
      S_REC        = 3'd2,
      S_REC_PAUSE  = 3'd3,
      S_PLAY       = 3'd4,
      S_PLAY_PAUSE = 3'd5
   } state_t;

   state_t            state, state_nx;
   logic              rec_start_nx, rec_pause_nx, rec_stop_nx;
   logic              dsp_start_nx, dsp_pause_nx, dsp_stop_nx;
   logic              latch_mode, finish_rec;
   logic [ADDR_W-1:0] end_addr_nx;
   logic              has_data_nx;
   logic              raw_stop, raw_pause, raw_record, raw_play;
   logic              key_stop, key_pause, key_record, key_play;

`ifdef AUD_CTRL_LOOP_EN
   // Keys arriving during the restart cycle are held and acted on one cycle later.
   logic       restart_q, restart_nx;
   logic [3:0] held_q, held_nx;
   assign {raw_stop, raw_pause, raw_record, raw_play} =
      {i_key_stop, i_key_pause, i_key_record, i_key_play} | held_q;
`else
   assign {raw_stop, raw_pause, raw_record, raw_play} =
      {i_key_stop, i_key_pause, i_key_record, i_key_play};
`endif

   assign key_stop   = raw_stop;
   assign key_pause  = raw_pause  & ~raw_stop;
   assign key_record = raw_record & ~raw_pause & ~raw_stop;
   assign key_play   = raw_play   & ~raw_record & ~raw_pause & ~raw_stop;

   always_comb begin
      state_nx     = state;
      rec_start_nx = 1'b0;
      rec_pause_nx = 1'b0;
      rec_stop_nx  = 1'b0;
      dsp_start_nx = 1'b0;
      dsp_pause_nx = 1'b0;
      dsp_stop_nx  = 1'b0;
      latch_mode   = 1'b0;
      finish_rec   = 1'b0;
      end_addr_nx  = o_end_addr;
      has_data_nx  = o_has_data;
`ifdef AUD_CTRL_LOOP_EN
      restart_nx   = 1'b0;
      held_nx      = 4'b0000;
`endif
      case (state)
         S_INIT: if (i_init_done) state_nx = S_IDLE;
         S_IDLE: begin
            if (key_record) begin
               state_nx     = S_REC;
               rec_start_nx = 1'b1;
            end else if (key_play && o_has_data) begin
               state_nx     = S_PLAY;
               dsp_start_nx = 1'b1;
               latch_mode   = 1'b1;
            end
         end
         S_REC: begin
            if (key_stop || i_rec_addr == MAX_ADDR) begin
               finish_rec = 1'b1;
            end else if (key_pause) begin
               state_nx     = S_REC_PAUSE;
               rec_pause_nx = 1'b1;
            end
         end
         S_REC_PAUSE: begin
            if (key_stop) begin
               finish_rec = 1'b1;
            end else if (key_record) begin
               state_nx     = S_REC;
               rec_start_nx = 1'b1;
            end
         end
         S_PLAY: begin
`ifdef AUD_CTRL_LOOP_EN
            if (restart_q) begin
               dsp_start_nx = 1'b1;
               held_nx      = {i_key_stop, i_key_pause, i_key_record, i_key_play};
            end else
`endif
            if (key_stop) begin
               state_nx    = S_IDLE;
               dsp_stop_nx = 1'b1;
            end else if (key_pause) begin
               state_nx     = S_PLAY_PAUSE;
               dsp_pause_nx = 1'b1;
            end else if (i_dsp_addr >= o_end_addr) begin
               dsp_stop_nx = 1'b1;
`ifdef AUD_CTRL_LOOP_EN
               restart_nx  = 1'b1;
`else
               state_nx    = S_IDLE;
`endif
            end
         end
         S_PLAY_PAUSE: begin
            if (key_stop) begin
               state_nx    = S_IDLE;
               dsp_stop_nx = 1'b1;
            end else if (key_play) begin
               state_nx     = S_PLAY;
               dsp_start_nx = 1'b1;
               latch_mode   = 1'b1;
            end
         end
         default: state_nx = S_INIT;
      endcase
      if (finish_rec) begin
         state_nx    = S_IDLE;
         rec_stop_nx = 1'b1;
         end_addr_nx = i_rec_addr;
         has_data_nx = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state        <= S_INIT;
         o_rec_start  <= 1'b0;
         o_rec_pause  <= 1'b0;
         o_rec_stop   <= 1'b0;
         o_dsp_start  <= 1'b0;
         o_dsp_pause  <= 1'b0;
         o_dsp_stop   <= 1'b0;
         o_dsp_speed  <= 3'd0;
         o_dsp_fast   <= 1'b0;
         o_dsp_slow_0 <= 1'b0;
         o_dsp_slow_1 <= 1'b0;
         o_sram_we_n  <= 1'b1;
         o_end_addr   <= '0;
         o_has_data   <= 1'b0;
`ifdef AUD_CTRL_LOOP_EN
         restart_q    <= 1'b0;
         held_q       <= 4'b0000;
`endif
      end else begin
         state        <= state_nx;
         o_rec_start  <= rec_start_nx;
         o_rec_pause  <= rec_pause_nx;
         o_rec_stop   <= rec_stop_nx;
         o_dsp_start  <= dsp_start_nx;
         o_dsp_pause  <= dsp_pause_nx;
         o_dsp_stop   <= dsp_stop_nx;
         o_sram_we_n  <= !(state_nx == S_REC || state_nx == S_REC_PAUSE);
         o_end_addr   <= end_addr_nx;
         o_has_data   <= has_data_nx;
         if (latch_mode) begin
            o_dsp_speed  <= i_sw_speed;
            o_dsp_fast   <= (i_sw_mode == 2'b01);
            o_dsp_slow_0 <= (i_sw_mode == 2'b10);
            o_dsp_slow_1 <= (i_sw_mode == 2'b11);
         end
`ifdef AUD_CTRL_LOOP_EN
         restart_q    <= restart_nx;
         held_q       <= held_nx;
`endif
      end
   end

   assign o_state = state;

endmodule

// File: tb/tb_aud_ctrl.sv
// Directed self-checking bench for aud_ctrl; expectations are hand-computed per step.
module tb_aud_ctrl;

   localparam int ADDR_W = 20;

   logic              i_clk = 1'b0;
   logic              i_rst_n, i_init_done;
   logic              i_key_record, i_key_play, i_key_pause, i_key_stop;
   logic [1:0]        i_sw_mode;
   logic [2:0]        i_sw_speed;
   logic [ADDR_W-1:0] i_rec_addr, i_dsp_addr;
   logic              o_rec_start, o_rec_pause, o_rec_stop;
   logic              o_dsp_start, o_dsp_pause, o_dsp_stop;
   logic [2:0]        o_dsp_speed;
   logic              o_dsp_fast, o_dsp_slow_0, o_dsp_slow_1;
   logic              o_sram_we_n;
   logic [ADDR_W-1:0] o_end_addr;
   logic              o_has_data;
   logic [2:0]        o_state;

   int checks = 0;
   int failures = 0;

   aud_ctrl #(.ADDR_W(ADDR_W), .MAX_ADDR(20'hFFFFF)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_init_done(i_init_done),
      .i_key_record(i_key_record), .i_key_play(i_key_play),
      .i_key_pause(i_key_pause), .i_key_stop(i_key_stop),
      .i_sw_mode(i_sw_mode), .i_sw_speed(i_sw_speed),
      .i_rec_addr(i_rec_addr), .i_dsp_addr(i_dsp_addr),
      .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause), .o_rec_stop(o_rec_stop),
      .o_dsp_start(o_dsp_start), .o_dsp_pause(o_dsp_pause), .o_dsp_stop(o_dsp_stop),
      .o_dsp_speed(o_dsp_speed), .o_dsp_fast(o_dsp_fast),
      .o_dsp_slow_0(o_dsp_slow_0), .o_dsp_slow_1(o_dsp_slow_1),
      .o_sram_we_n(o_sram_we_n), .o_end_addr(o_end_addr),
      .o_has_data(o_has_data), .o_state(o_state)
   );

   always #5 i_clk = ~i_clk;

   // Pulse vector order: rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop
   function automatic logic [5:0] pulses();
      return {o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause, o_dsp_stop};
   endfunction

   function automatic logic [2:0] modeBits();
      return {o_dsp_fast, o_dsp_slow_0, o_dsp_slow_1};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // keys = {stop, pause, record, play}; held for exactly one rising edge
   task automatic applyStimulus(input logic [3:0] keys);
      @(negedge i_clk);
      {i_key_stop, i_key_pause, i_key_record, i_key_play} = keys;
      @(posedge i_clk);
      #1;
      {i_key_stop, i_key_pause, i_key_record, i_key_play} = 4'b0000;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_rst_n = 1'b0; i_init_done = 1'b0;
      {i_key_stop, i_key_pause, i_key_record, i_key_play} = 4'b0000;
      i_sw_mode = 2'b00; i_sw_speed = 3'd0;
      i_rec_addr = '0; i_dsp_addr = '0;
      repeat (3) tick();
      checkOutput("rst_state", o_state, 3'd0);
      checkOutput("rst_pulses", pulses(), 6'b000000);
      checkOutput("rst_we_n", o_sram_we_n, 1'b1);
      checkOutput("rst_has_data", o_has_data, 1'b0);
      checkOutput("rst_end_addr", o_end_addr, 20'h00000);
      checkOutput("rst_mode", {modeBits(), o_dsp_speed}, 6'b000000);

      @(negedge i_clk) i_rst_n = 1'b1;
      applyStimulus(4'b0010);
      checkOutput("init_key_ignored", pulses(), 6'b000000);
      checkOutput("init_hold_state", o_state, 3'd0);
      @(negedge i_clk) i_init_done = 1'b1;
      tick();
      checkOutput("init_to_idle", o_state, 3'd1);

      applyStimulus(4'b0001);
      checkOutput("play_nodata_pulses", pulses(), 6'b000000);
      checkOutput("play_nodata_state", o_state, 3'd1);

      applyStimulus(4'b0010);
      checkOutput("rec_start", pulses(), 6'b100000);
      checkOutput("rec_state", o_state, 3'd2);
      checkOutput("rec_we_n", o_sram_we_n, 1'b0);
      tick();
      checkOutput("rec_start_one_cycle", pulses(), 6'b000000);

      @(negedge i_clk) i_rec_addr = 20'h01234;
      applyStimulus(4'b0001);
      checkOutput("rec_play_ignored", {pulses(), o_state}, {6'b000000, 3'd2});
      applyStimulus(4'b1000);
      checkOutput("rec_stop", pulses(), 6'b001000);
      checkOutput("rec_stop_state", o_state, 3'd1);
      checkOutput("rec_end_addr", o_end_addr, 20'h01234);
      checkOutput("rec_has_data", o_has_data, 1'b1);
      checkOutput("rec_stop_we_n", o_sram_we_n, 1'b1);

      applyStimulus(4'b0010);
      applyStimulus(4'b0100);
      checkOutput("rec_pause", {pulses(), o_state, o_sram_we_n}, {6'b010000, 3'd3, 1'b0});
      applyStimulus(4'b0010);
      checkOutput("rec_resume", {pulses(), o_state}, {6'b100000, 3'd2});

      @(negedge i_clk) i_rec_addr = 20'hFFFFF;
      tick();
      checkOutput("full_stop", {pulses(), o_state}, {6'b001000, 3'd1});
      checkOutput("full_end_addr", o_end_addr, 20'hFFFFF);

      applyStimulus(4'b0010);
      @(negedge i_clk) i_rec_addr = 20'h00100;
      applyStimulus(4'b1000);
      checkOutput("rerec_end_addr", o_end_addr, 20'h00100);

      @(negedge i_clk) begin i_sw_mode = 2'b11; i_sw_speed = 3'd3; end
      applyStimulus(4'b0001);
      checkOutput("play_start", {pulses(), o_state, o_sram_we_n}, {6'b000100, 3'd4, 1'b1});
      checkOutput("play_latch", {modeBits(), o_dsp_speed}, {3'b001, 3'd3});
      @(negedge i_clk) begin i_sw_mode = 2'b01; i_sw_speed = 3'd7; end
      tick();
      checkOutput("play_sw_no_effect", {modeBits(), o_dsp_speed, pulses()}, {3'b001, 3'd3, 6'b000000});

      applyStimulus(4'b0100);
      checkOutput("play_pause", {pulses(), o_state}, {6'b000010, 3'd5});
      applyStimulus(4'b0010);
      checkOutput("pause_rec_ignored", {pulses(), o_state}, {6'b000000, 3'd5});
      applyStimulus(4'b0001);
      checkOutput("play_resume", {pulses(), o_state}, {6'b000100, 3'd4});
      checkOutput("play_relatch", {modeBits(), o_dsp_speed}, {3'b100, 3'd7});

      @(negedge i_clk) i_dsp_addr = 20'h000FF;
      tick();
      checkOutput("play_below_end", {pulses(), o_state}, {6'b000000, 3'd4});
      @(negedge i_clk) i_dsp_addr = 20'h00100;
      tick();
`ifdef AUD_CTRL_LOOP_EN
      checkOutput("loop_stop", {pulses(), o_state}, {6'b000001, 3'd4});
      @(negedge i_clk) i_dsp_addr = 20'h00000;
      tick();
      checkOutput("loop_restart", {pulses(), o_state}, {6'b000100, 3'd4});
      checkOutput("loop_mode_kept", {modeBits(), o_dsp_speed}, {3'b100, 3'd7});
      applyStimulus(4'b1000);
      checkOutput("loop_key_stop", {pulses(), o_state}, {6'b000001, 3'd1});
`else
      checkOutput("play_end", {pulses(), o_state}, {6'b000001, 3'd1});
      @(negedge i_clk) i_dsp_addr = 20'h00000;
`endif

      @(negedge i_clk) begin i_sw_mode = 2'b10; i_sw_speed = 3'd0; end
      applyStimulus(4'b0001);
      checkOutput("play2_latch", {modeBits(), o_dsp_speed, o_state}, {3'b010, 3'd0, 3'd4});
      applyStimulus(4'b1100);
      checkOutput("prio_stop_over_pause", {pulses(), o_state}, {6'b000001, 3'd1});
      applyStimulus(4'b0011);
      checkOutput("prio_rec_over_play", {pulses(), o_state}, {6'b100000, 3'd2});

      @(negedge i_clk) i_rec_addr = 20'h00005;
      @(negedge i_clk) i_rst_n = 1'b0;
      tick();
      checkOutput("midop_rst_state", o_state, 3'd0);
      checkOutput("midop_rst_we_n", o_sram_we_n, 1'b1);
      checkOutput("midop_rst_has_data", o_has_data, 1'b0);
      checkOutput("midop_rst_pulses", pulses(), 6'b000000);
      checkOutput("midop_rst_end_addr", o_end_addr, 20'h00000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
